// File: rtl/fix_tx_fifo.sv
// fix_tx_fifo: message-framed FIX engine to TOE transmit buffer with hold register and show-ahead output.
// Define FIX_TX_STORE_FWD_EN for store-and-forward; otherwise bytes cut through as soon as committed.
module fix_tx_fifo #(
  parameter int DEPTH       = 512,
  parameter int AW          = $clog2(DEPTH),
  parameter int FULL_MARGIN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_write_i,
  input  logic [7:0]    message_i,
  input  logic          end_i,
  output logic          fifo_full_o,
  output logic          tx_valid_o,
  output logic [7:0]    tx_data_o,
  output logic          tx_last_o,
  input  logic          tx_ready_i,
  output logic [AW:0]   msg_count_o,
  output logic          overflow_o
);
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count, r_msg_count;
  logic          r_hold_v, r_hold_l, r_tx_v, r_tx_l, r_full, r_ovf;
  logic [7:0]    r_hold_d, r_tx_d;
  logic          w_commit, w_commit_l, w_room, w_wr, w_acc, w_pop, w_rd_ok;
  logic [AW:0]   w_ram_n;
  logic [AW+1:0] w_occ;
  logic [8:0]    w_head;
  // r_count covers RAM plus the output register, so RAM never aliases full/empty.
  assign w_commit   = r_hold_v & (r_hold_l | fifo_write_i | end_i);
  assign w_commit_l = r_hold_l | (end_i & ~fifo_write_i);
  assign w_room     = r_count != (AW+1)'(DEPTH);
  assign w_wr       = w_commit & w_room;
  assign w_acc      = r_tx_v & tx_ready_i;
  assign w_ram_n    = r_count - {{AW{1'b0}}, r_tx_v};
  assign w_occ      = {1'b0, r_count} + {{(AW+1){1'b0}}, r_hold_v};
  assign w_head     = r_mem[r_rd_ptr];
  assign w_pop      = (~r_tx_v | tx_ready_i) & (w_ram_n != '0) & w_rd_ok;
`ifdef FIX_TX_STORE_FWD_EN
  logic r_mid;
  // A message already leaving via the output register is not counted as waiting.
  assign w_rd_ok = r_mid | (r_msg_count > {{AW{1'b0}}, r_tx_v & r_tx_l});
  always_ff @(posedge clk or posedge rst)
    if (rst) r_mid <= 1'b0;
    else if (w_pop) r_mid <= ~w_head[8];
`else
  assign w_rd_ok = 1'b1;
`endif
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= {w_commit_l, r_hold_d};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_msg_count <= '0;
      r_hold_v    <= 1'b0;
      r_hold_l    <= 1'b0;
      r_hold_d    <= '0;
      r_tx_v      <= 1'b0;
      r_tx_l      <= 1'b0;
      r_tx_d      <= '0;
      r_full      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + AW'(w_wr);
      r_rd_ptr    <= r_rd_ptr + AW'(w_pop);
      r_count     <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_acc);
      r_msg_count <= r_msg_count + (AW+1)'(w_wr & w_commit_l) - (AW+1)'(w_acc & r_tx_l);
      r_full      <= w_occ >= (AW+2)'(DEPTH - FULL_MARGIN);
      r_ovf       <= r_ovf | (w_commit & ~w_room);
      if (fifo_write_i) begin
        r_hold_v <= 1'b1;
        r_hold_d <= message_i;
        r_hold_l <= end_i;
      end else if (w_commit) begin
        r_hold_v <= 1'b0;
        r_hold_l <= 1'b0;
      end
      if (w_pop) begin
        r_tx_v <= 1'b1;
        r_tx_d <= w_head[7:0];
        r_tx_l <= w_head[8];
      end else if (w_acc) begin
        r_tx_v <= 1'b0;
      end
    end
  end
  assign fifo_full_o = r_full;
  assign tx_valid_o  = r_tx_v;
  assign tx_data_o   = r_tx_d;
  assign tx_last_o   = r_tx_l;
  assign msg_count_o = r_msg_count;
  assign overflow_o  = r_ovf;
endmodule

// File: tb/tb_fix_tx_fifo.sv
// tb_fix_tx_fifo: vector table, corner sequences and random traffic against a queue-based model of fix_tx_fifo.
module tb_fix_tx_fifo;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int FM    = 4;
  logic clk = 1'b0, rst = 1'b1, wr = 1'b0, en = 1'b0, rdy = 1'b0;
  logic [7:0] msg = '0;
  logic full, tv, tl, ov;
  logic [7:0] td;
  logic [AW:0] mc;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  fix_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .FULL_MARGIN(FM)) dut (
    .clk(clk), .rst(rst), .fifo_write_i(wr), .message_i(msg), .end_i(en),
    .fifo_full_o(full), .tx_valid_o(tv), .tx_data_o(td), .tx_last_o(tl),
    .tx_ready_i(rdy), .msg_count_o(mc), .overflow_o(ov)
  );
  logic [8:0] q[$];
  bit hv, hl, tv_m, tl_m, ov_m, full_m, mid_m;
  logic [7:0] hd, td_m;
  int mc_m;
  task automatic m_reset();
    q.delete();
    hv = 0; hl = 0; hd = '0; tv_m = 0; tl_m = 0; td_m = '0;
    ov_m = 0; full_m = 0; mid_m = 0; mc_m = 0;
  endtask
  task automatic m_step();
    bit acc, commit, cl, drop, rdok, tl_pre;
    int occ;
    occ    = q.size() + int'(tv_m);
    acc    = tv_m && rdy;
    tl_pre = tl_m;
    commit = hv && (hl || wr || en);
    cl     = hl || (en && !wr);
    drop   = commit && occ == DEPTH;
    full_m = (occ + int'(hv)) >= DEPTH - FM;
    rdok   = 1;
`ifdef FIX_TX_STORE_FWD_EN
    rdok   = mid_m || (mc_m > int'(tv_m && tl_m));
`endif
    if ((!tv_m || rdy) && q.size() > 0 && rdok) begin
      {tl_m, td_m} = q.pop_front();
      tv_m  = 1;
      mid_m = !tl_m;
    end else if (acc) tv_m = 0;
    if (commit && !drop) q.push_back({cl, hd});
    if (drop) ov_m = 1;
    mc_m = mc_m + int'(commit && cl && !drop) - int'(acc && tl_pre);
    if (wr) begin hv = 1; hd = msg; hl = en; end
    else if (commit) begin hv = 0; hl = 0; end
  endtask
  task automatic cmp(input string tag);
    checks++;
    if (full !== full_m || tv !== tv_m || (tv_m && (td !== td_m || tl !== tl_m)) ||
        mc !== (AW+1)'(mc_m) || ov !== ov_m) begin
      failures++;
      $display("FAIL %s t=%0t got full=%b v=%b d=%h l=%b mc=%0d ov=%b want full=%b v=%b d=%h l=%b mc=%0d ov=%b",
               tag, $time, full, tv, td, tl, mc, ov, full_m, tv_m, td_m, tl_m, mc_m, ov_m);
    end
  endtask
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, exp);
    end
  endtask
  task automatic cyc(input bit w, input logic [7:0] d, input bit e, input bit r);
    wr = w; msg = d; en = e; rdy = r;
    @(posedge clk);
    m_step();
    @(negedge clk);
    cmp("model");
  endtask
  task automatic sync_reset();
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask
  typedef struct {
    bit w; logic [7:0] d; bit e; bit r;
    bit ev; logic [7:0] ed; bit el; int emc;
  } vec_t;
  vec_t vt[8];
  initial begin
    int n, acc_n;
    logic [7:0] last_d;
    vt[0] = '{1'b1, 8'h38, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
    vt[1] = '{1'b1, 8'h3D, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
    vt[2] = '{1'b1, 8'h46, 1'b0, 1'b1, 1'b1, 8'h38, 1'b0, 0};
    vt[3] = '{1'b1, 8'h49, 1'b0, 1'b1, 1'b1, 8'h3D, 1'b0, 0};
    vt[4] = '{1'b1, 8'h58, 1'b1, 1'b1, 1'b1, 8'h46, 1'b0, 0};
    vt[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h49, 1'b0, 1};
    vt[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h58, 1'b1, 1};
    vt[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_full", int'(full), 0);
    chk("rst_valid", int'(tv), 0);
    chk("rst_data", int'(td), 0);
    chk("rst_last", int'(tl), 0);
    chk("rst_mc", int'(mc), 0);
    chk("rst_ovf", int'(ov), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(vt[i].w, vt[i].d, vt[i].e, vt[i].r);
      chk($sformatf("fix_valid[%0d]", i), int'(tv), int'(vt[i].ev));
      if (vt[i].ev) begin
        chk($sformatf("fix_data[%0d]", i), int'(td), int'(vt[i].ed));
        chk($sformatf("fix_last[%0d]", i), int'(tl), int'(vt[i].el));
      end
      chk($sformatf("fix_mc[%0d]", i), int'(mc), vt[i].emc);
    end
    cyc(1, 8'hA1, 0, 0); cyc(1, 8'hA2, 0, 0); cyc(1, 8'hA3, 0, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    chk("lone_end_pre_mc", int'(mc), 0);
    cyc(0, 0, 1, 0);
    chk("lone_end_mc", int'(mc), 1);
    cyc(0, 0, 1, 0);
    chk("lone_end_ignored_mc", int'(mc), 1);
    repeat (5) cyc(0, 0, 0, 1);
    chk("lone_end_drained_mc", int'(mc), 0);
    cyc(1, 8'h41, 0, 0); cyc(1, 8'h42, 1, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("simul_pre_last", int'(tv && tl), 1);
    cyc(1, 8'h43, 1, 0);
    chk("simul_pre_mc", int'(mc), 1);
    cyc(0, 0, 0, 1);
    chk("simul_mc_unchanged", int'(mc), 1);
    repeat (4) cyc(0, 0, 0, 1);
    chk("simul_drained_mc", int'(mc), 0);
    for (int i = 0; i < 8; i++) cyc(1, 8'(8'h70 + i), 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", int'(tv), 0);
    chk("arst_data", int'(td), 0);
    chk("arst_mc", int'(mc), 0);
    chk("arst_full_ovf", int'({full, ov, tl}), 0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 8'h55, 0, 1); cyc(1, 8'h66, 1, 1);
    acc_n = 0; last_d = '0;
    for (int i = 0; i < 8; i++) begin
      if (tv) begin acc_n++; last_d = td; end
      cyc(0, 0, 0, 1);
    end
    chk("arst_new_msg_bytes", acc_n, 2);
    chk("arst_new_msg_last", int'(last_d), 'h66);
    sync_reset();
    for (int i = 0; i < DEPTH - FM; i++) cyc(1, 8'(i), 0, 0);
    chk("full_not_yet", int'(full), 0);
    cyc(0, 0, 0, 0);
    chk("full_set", int'(full), 1);
    for (int i = DEPTH - FM; i < DEPTH + 2; i++) begin
      cyc(1, 8'(i), 0, 0);
      if (i == DEPTH) chk("ovf_not_yet", int'(ov), 0);
    end
    chk("ovf_set", int'(ov), 1);
    n = 0;
    for (int i = 0; i < DEPTH + 8; i++) begin
      if (tv) begin
        if (td !== 8'(n)) begin
          checks++; failures++;
          $display("FAIL drain_byte idx=%0d got=%h want=%h", n, td, 8'(n));
        end
        n++;
      end
      cyc(0, 0, 0, 1);
    end
    chk("drain_count", n, DEPTH);
    chk("ovf_sticky", int'(ov), 1);
    sync_reset();
    for (int i = 0; i < 3000; i++) begin
      bit w, e, r;
      w = $urandom_range(0, 9) < 6;
      e = $urandom_range(0, 9) < 2;
      r = ((i / 400) % 3 == 1) ? ($urandom_range(0, 9) < 1) : ($urandom_range(0, 9) < 6);
      cyc(w, 8'($urandom), e, r);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fix_tx_fifo.md
# fix_tx_fifo

Message-framed transmit buffer between the FIX engine byte output (`fifo_write`, `message`, `end`) and the TCP offload engine (TOE) transmit port. It absorbs the engine's byte stream and binds a trailing end-of-message strobe to the last byte through a one-entry hold register. It stores bytes with a per-entry last flag and replays whole messages to the TOE over a valid/ready handshake. It drives the engine's `fifo_full` backpressure input.

## Interface
- `DEPTH`, 512 — RAM entries (byte + last flag); power of two.
- `AW`, $clog2(DEPTH) — pointer width.
- `FULL_MARGIN`, 4 — free-slot threshold for asserting `fifo_full_o`; covers engine reaction latency.
- `clk`  in  1  — single clock, all logic on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `fifo_write_i`  in  1  — engine byte strobe.
- `message_i`  in  8  — engine byte.
- `end_i`  in  1  — engine end-of-message strobe.
- `fifo_full_o`  out  1  — backpressure to engine.
- `tx_valid_o`  out  1  — output byte valid.
- `tx_data_o`  out  8  — output byte.
- `tx_last_o`  out  1  — final byte of message.
- `tx_ready_i`  in  1  — TOE accepts byte.
- `msg_count_o`  out  AW+1  — complete messages resident in RAM.
- `overflow_o`  out  1  — sticky: a commit was dropped because RAM was full.

## Operation
- The hold register (`hold_v`, `hold_d`, `hold_l`) sits in front of the RAM. A commit writes `{hold_l, hold_d}` at `wr_ptr` and increments the pointer.
- `fifo_write_i` with `end_i`=0:
  - Commit the hold if `hold_v`.
  - Load `message_i` into the hold with `hold_l`=0.
- `fifo_write_i` with `end_i`=1:
  - Commit the existing hold.
  - Load `message_i` with `hold_l`=1.
  - A hold with `hold_l`=1 auto-commits on the next cycle. A new write in that same cycle is loaded normally, with no loss.
- `end_i` alone:
  - If `hold_v`, set `hold_l` and commit this cycle.
  - If no hold is pending, ignore it (no empty messages are created).
- Hold with `hold_l`=0 and no further input: waits indefinitely.
- Commit when RAM is full (`count`==DEPTH): drop the byte, set `overflow_o`. If the dropped byte had `last`=1, `msg_count_o` is not incremented.
- `msg_count_o`:
  - +1 on commit of a last byte.
  - −1 on accept (`tx_valid_o` & `tx_ready_i` & `tx_last_o`).
  - Both in the same cycle: unchanged.
- `fifo_full_o` = (RAM count + `hold_v`) ≥ DEPTH − FULL_MARGIN, registered.
- Output register is show-ahead:
  - It refills from the RAM head whenever it is empty or its byte is accepted, provided the read is permitted.
  - Sustains one byte per cycle while `tx_ready_i`=1.
- Reset (async, any time, including mid-message): pointers, count, hold, output register, `msg_count_o` and `overflow_o` all clear. A partial message is discarded.
- Reset values of outputs:
  - `fifo_full_o`=0, `tx_valid_o`=0, `tx_data_o`=8'h00, `tx_last_o`=0, `msg_count_o`=0, `overflow_o`=0.

## Timing
- Byte written at edge N enters the hold. It commits at the edge of the next `fifo_write_i` or `end_i`, or at N+1 if tagged last. The committed byte appears on `tx_valid_o` one edge after commit (cut-through).
- `fifo_full_o` reflects the occupancy after edge N at edge N+1. Writes arriving while it is high are still accepted until the RAM is truly full.
- `tx_data_o`/`tx_last_o` hold stable while `tx_valid_o`=1 and `tx_ready_i`=0.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by the AW+1-bit count.

## Configuration
- `FIX_TX_STORE_FWD_EN` defined: store-and-forward. The output register may load the first byte of a message only when `msg_count_o` > 0. Bytes within a message flow once its first byte is loaded. The first byte appears one edge after the last-byte commit at the earliest.
- Undefined: cut-through. Any committed byte may be loaded; `msg_count_o` is still maintained.

## Test plan
- Reset, then write "8=FIX" with `end_i` on the same cycle as 'X', `tx_ready_i`=1 → `tx_data_o` = 38 3D 46 49 58 on consecutive cycles, `tx_last_o` only with 58, `msg_count_o` 0→1→0.
- Write 3 bytes, then pulse `end_i` alone two cycles later → third byte is committed with `last`=1; a second lone `end_i` is ignored (`msg_count_o` stays 1).
- `tx_ready_i`=0, write DEPTH−FULL_MARGIN bytes → `fifo_full_o`=1 one edge later. Keep writing → the byte past DEPTH sets `overflow_o`=1; the RAM content is unchanged.
- With `FIX_TX_STORE_FWD_EN`, write a 10-byte message with a 5-cycle gap mid-message → `tx_valid_o` stays 0 until the edge after the last-byte commit. Without the macro, the first byte appears during the gap.
- Assert `rst` asynchronously mid-message with 7 bytes stored → all outputs drop to their reset values immediately. After release, a new 2-byte message is delivered alone.
- Simultaneous last-byte commit and `tx_last_o` accept → `msg_count_o` unchanged.
